// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types, SPI SRAM commands and transfer-size helper
package sram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    GAP   = 2'd3
  } state_e;

  function automatic logic [2:0] nbytes(input size_e size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/sram_spi_arbiter_if.sv
// rtl/sram_spi_arbiter_if.sv - fetch and data requester bus into the SRAM arbiter
interface sram_spi_arbiter_if #(
  parameter int ADDR_W = 24
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ready;
  logic [31:0]       rdata;

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata,
    input  if_ready, d_ready, rdata
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata,
    output if_ready, d_ready, rdata
  );
endinterface

// File: rtl/sram_spi_phy.sv
// rtl/sram_spi_phy.sv - SPI mode-0 shifter: sclk divider, tx/rx shift registers, bit counter
module sram_spi_phy #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] tx_bits,
  input  logic [6:0]  nbits,
  output logic        busy,
  output logic        done,
  output logic [31:0] rx,
  output logic        ce,
  output logic        sclk,
  output logic        si,
  input  logic        so
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [63:0]      shreg;
  logic [6:0]       bits_left;
  logic             phase_end;

  assign phase_end = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      rx        <= 32'h0;
      ce        <= 1'b1;
      sclk      <= 1'b0;
      si        <= 1'b0;
      shreg     <= 64'h0;
      bits_left <= 7'd0;
      div_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy      <= 1'b1;
          ce        <= 1'b0;
          sclk      <= 1'b0;
          si        <= tx_bits[63];
          shreg     <= {tx_bits[62:0], 1'b0};
          bits_left <= nbits - 7'd1;
          div_cnt   <= '0;
        end
      end else if (phase_end) begin
        div_cnt <= '0;
        if (!sclk) begin
          // rising edge: the SRAM has held so stable since the previous falling edge
          sclk <= 1'b1;
          rx   <= {rx[30:0], so};
        end else begin
          sclk <= 1'b0;
          if (bits_left == 7'd0) begin
            busy <= 1'b0;
            done <= 1'b1;
            ce   <= 1'b1;
            si   <= 1'b0;
          end else begin
            si        <= shreg[63];
            shreg     <= {shreg[62:0], 1'b0};
            bits_left <= bits_left - 7'd1;
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_spi_arbiter.sv
// rtl/sram_spi_arbiter.sv - round-robin arbiter sharing one SPI SRAM between fetch and data ports
module sram_spi_arbiter
  import sram_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int ADDR_W  = 24
) (
  input  logic               clk,
  input  logic               reset,
  sram_spi_arbiter_if.slave  bus,
  output logic               sram_ce,
  output logic               sclk,
  output logic               si,
  input  logic               so
);

  state_e            state, next_state;
  logic              last_port;
  logic              cur_port;
  logic              cur_we;
  logic [2:0]        cur_nbytes;
  logic              if_ready_q, d_ready_q;
  logic [31:0]       rdata_q;

  logic              any_req, grant_port, grant_we;
  size_e             d_sz;
  logic [2:0]        grant_nbytes;
  logic [ADDR_W-1:0] grant_addr;
  logic [31:0]       wdata_wire;
  logic [63:0]       tx_bits;
  logic [6:0]        nbits;
  logic              phy_start, phy_busy, phy_done;
  logic [31:0]       phy_rx;

  // on a tie, serve the port that was not served last
  assign any_req      = bus.if_req || bus.d_req;
  assign grant_port   = bus.d_req && (!bus.if_req || !last_port);
  assign grant_we     = grant_port && bus.d_we;
  assign d_sz         = (bus.d_size == 2'd3) ? SZ_WORD : size_e'(bus.d_size);
  assign grant_nbytes = grant_port ? nbytes(d_sz) : 3'd4;
  assign grant_addr   = grant_port ? bus.d_addr : bus.if_addr;
  assign wdata_wire   = {bus.d_wdata[7:0], bus.d_wdata[15:8], bus.d_wdata[23:16], bus.d_wdata[31:24]};
  assign tx_bits      = {grant_we ? CMD_WRITE : CMD_READ, 24'(grant_addr), grant_we ? wdata_wire : 32'h0};
  assign nbits        = 7'd32 + {1'b0, grant_nbytes, 3'b000};

  // rx holds the last 32 bits received, first data byte highest; repack little-endian
  function automatic logic [31:0] pack_rx(input logic [31:0] r, input logic [2:0] n);
    case (n)
      3'd1:    return {24'h0, r[7:0]};
      3'd2:    return {16'h0, r[7:0], r[15:8]};
      default: return {r[7:0], r[15:8], r[23:16], r[31:24]};
    endcase
  endfunction

  sram_spi_phy #(.CLK_DIV(CLK_DIV)) u_phy (
    .clk     (clk),
    .reset   (reset),
    .start   (phy_start),
    .tx_bits (tx_bits),
    .nbits   (nbits),
    .busy    (phy_busy),
    .done    (phy_done),
    .rx      (phy_rx),
    .ce      (sram_ce),
    .sclk    (sclk),
    .si      (si),
    .so      (so)
  );

  always_comb begin
    next_state = state;
    phy_start  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && !phy_busy) begin
          phy_start  = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT:   if (phy_done) next_state = DONE;
      DONE:    next_state = GAP;
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_port  <= 1'b1;
      cur_port   <= 1'b0;
      cur_we     <= 1'b0;
      cur_nbytes <= 3'd4;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      state      <= next_state;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if (phy_start) begin
        cur_port   <= grant_port;
        last_port  <= grant_port;
        cur_we     <= grant_we;
        cur_nbytes <= grant_nbytes;
      end
      if (state == SHIFT && phy_done) begin
        if_ready_q <= !cur_port;
        d_ready_q  <= cur_port;
        rdata_q    <= cur_we ? 32'h0 : pack_rx(phy_rx, cur_nbytes);
      end
    end
  end

  assign bus.if_ready = if_ready_q;
  assign bus.d_ready  = d_ready_q;
  assign bus.rdata    = rdata_q;

endmodule

// File: doc/sram_spi_arbiter.md
Name: sram_spi_arbiter

Overview:
- Shares the single external SPI SRAM (si, sclk, sram_ce, so pins) between two CPU requesters: port 0 is instruction fetch (word read only); port 1 is data (read/write, byte/half/word).
- Round-robin arbitration between the two ports.
- Sequences one SPI mode-0 transaction per grant: 8-bit command, 24-bit address, 8/16/32 data bits, MSB-first per byte.
- Sits inside cpu, between the fetch/LSU and the pads.

Parameters:
- CLK_DIV, 1: clk cycles per sclk half-period (≥1); sclk = clk/(2*CLK_DIV).
- ADDR_W, 24: byte-address width; always zero-extended/truncated to 24 bits on the wire.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- if_req  input  1  port 0 request (word read)
- if_addr  input  ADDR_W  port 0 byte address
- if_ready  output  1  port 0 completion pulse
- d_req  input  1  port 1 request
- d_we  input  1  port 1 write (1) / read (0)
- d_size  input  2  0=byte, 1=half, 2 or 3=word
- d_addr  input  ADDR_W  port 1 byte address
- d_wdata  input  32  write data; byte 0 in [7:0]
- d_ready  output  1  port 1 completion pulse
- rdata  output  32  read data, valid on the cycle a ready pulse is high; shared by both ports
- sram_ce  output  1  chip enable, active-low; 1 = deselected
- sclk  output  1  SPI clock, idle low
- si  output  1  serial data to SRAM
- so  input  1  serial data from SRAM

Behaviour:
Reset (synchronous, takes effect at any point, including mid-transaction):
- sram_ce=1, sclk=0, si=0, if_ready=0, d_ready=0, rdata=0.
- State=IDLE; round-robin pointer favours port 0.
- An in-flight transaction is abandoned; no ready pulse is generated.

States: IDLE -> SHIFT -> DONE -> GAP -> IDLE.

IDLE:
- Samples requests each cycle.
- Only one requesting: grant it.
- Both requesting: grant the port not served last; after reset, port 0 wins the first tie.
- On grant, latch port, command, address, wdata and bit count, then go to SHIFT. All outputs are registered.
- Command: 8'h03 for reads (port 0 always reads), 8'h02 for port 1 writes.
- Bit count NB = 32 + 8*nbytes, where nbytes = 1/2/4 per d_size; port 0 always uses 4.

SHIFT:
- sram_ce=0 from the first SHIFT cycle, with the first bit (command MSB) already on si.
- Each bit lasts 2*CLK_DIV cycles: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
- so is sampled on the clk edge where sclk goes 0->1.
- si advances to the next bit when sclk goes 1->0.
- Bit order: command [7:0] MSB first; address [23:0] MSB first; data byte 0, byte 1, ..., each byte MSB first.
- After the last bit's high phase, sclk returns to 0 and the state moves to DONE.

DONE (1 cycle):
- sram_ce=1, si=0.
- Ready pulse on the granted port only, for exactly 1 cycle.
- rdata holds the received bytes little-endian: first byte received goes to [7:0]; unused upper bytes are 0.
- On writes rdata = 0.

GAP (1 cycle):
- sram_ce stays 1 (CS high time), then IDLE.

Timing:
- Latency from the req-sampled cycle to the ready pulse = 1 + 2*CLK_DIV*NB cycles.
- With CLK_DIV=1: word = 129 cycles, byte = 81 cycles.
- Minimum request-to-request spacing = latency + 2 cycles.

Requester rules and edge cases:
- The requester must hold req and its inputs stable until its ready pulse.
- A request dropped mid-transaction still completes and still pulses ready.
- A request still high in the cycle after ready is a new request.
- No alignment check: the SRAM runs in sequential mode, and address wrap at 2^24 is the SRAM's concern.
- rdata is held until the next DONE.

Decomposition:
- Package sram_pkg: CMD_READ=8'h03, CMD_WRITE=8'h02; size_e (SZ_BYTE, SZ_HALF, SZ_WORD); state_e (IDLE, SHIFT, DONE, GAP); function nbytes(size_e).
- One sub-module, sram_spi_phy. It holds the sclk divider, the shift-out/shift-in register and the bit counter, with a start/busy/done handshake.
- The arbiter plus the FSM are in sram_spi_arbiter.

Test Plan:
- Reset, then if_req=1, if_addr=24'h000100, SRAM model returns bytes 13,37,BE,EF -> si carries 03 000100; if_ready pulses at cycle 129; rdata=32'hEFBE3713; sram_ce low for exactly 128 cycles.
- d_req write, d_size=0, d_addr=24'h00ABCD, d_wdata=32'h5A -> si carries 02 00ABCD 5A (40 bits); d_ready pulses at cycle 81; rdata=0; sram_ce high during DONE and GAP.
- if_req and d_req both high from reset -> port 0 served first, then port 1. With both re-held, the next grants alternate 1, 0.
- Half-word read with CLK_DIV=3, model returns A1,B2 -> sclk period 6 clk; rdata=32'h0000B2A1; d_ready at 1+6*48=289.
- reset asserted at cycle 40 of a word read -> next cycle sram_ce=1, sclk=0, no if_ready. A fresh if_req after reset completes normally.
- Port 1 drops d_req mid-transaction -> transaction still completes and d_ready pulses once; no duplicate transaction follows.
